ghash_ctrl: RTL
===============

// Module: ghash_ctrl
// PURPOSE
//  Sequences the gf128_mult datapath to compute GHASH_H(A,C) per NIST SP 800-38D:
//  Y <- (Y ^ X_i) * H for every 128-bit block, then returns the final Y as the tag.
//  Sits between the AES-CTR engine (AAD and ciphertext blocks) and the tag XOR stage.
//  Holds H. Orders AAD before CT. Owns one gf128_mult instance.
// PARAMETERS
//  MULT_CYCLES  1  cycles allotted per multiply (1..4); values >1 allow a multicycle-path constraint
// PORTS
//  clk        in   1    clock, rising edge
//  rst_n      in   1    asynchronous reset, active-low
//  h_load     in   1    pulse: capture h_in as hash subkey H
//  h_in       in   128  hash subkey, GCM bit order (bit127 = x^0)
//  start      in   1    pulse: begin a new message (clear Y and counters)
//  blk_valid  in   1    input block valid
//  blk_ready  out  1    input block accepted when valid&ready
//  blk_data   in   128  block, GCM bit order, first byte in [127:120]
//  blk_type   in   1    0 = AAD, 1 = ciphertext
//  blk_last   in   1    last block of the message
//  blk_bytes  in   5    valid bytes in block (1..16; 0 only with blk_last, see BEHAVIOUR)
//  busy       out  1    message in progress (state != IDLE)
//  tag_valid  out  1    tag_out valid; held until tag_ready
//  tag_ready  in   1    tag consumer ready
//  tag_out    out  128  GHASH result
//  err        out  1    1-cycle pulse on protocol violation (block dropped or h_load ignored)
// BEHAVIOUR
//  Reset: H=0, Y=0, counters=0, state IDLE. Outputs reset to: blk_ready=0, busy=0, tag_valid=0, tag_out=0, err=0.
//  FSM states: IDLE, ACCUM, WAIT, LEN, DONE.
//   IDLE : blk_ready=0. On start: Y<=0, seen_ct<=0, counters<=0 -> ACCUM.
//   ACCUM: blk_ready=1. On accept: Y<=(Y^Xm)*H, where Xm = blk_data with bytes at index >= blk_bytes zeroed.
//          Transition on accept: MULT_CYCLES>1 -> WAIT; else (last -> LEN/DONE) or stay in ACCUM.
//   WAIT : blk_ready=0 for MULT_CYCLES-1 cycles; Y registered at end. Then -> ACCUM, LEN or DONE per the latched blk_last.
//   LEN  : Y<=(Y^{aad_bits[63:0],ct_bits[63:0]})*H, same MULT_CYCLES timing -> DONE.
//   DONE : tag_valid=1, tag_out=Y. On tag_valid&tag_ready -> IDLE, same cycle.
//  Throughput: one block per MULT_CYCLES clocks; tag_valid rises MULT_CYCLES cycles after the final multiply starts.
//  Order and protocol errors:
//   - AAD block after any CT block: err pulse, block consumed and not hashed, counters unchanged.
//   - blk_bytes=0 with blk_last: block not hashed; terminates the message (empty-C / empty-message case).
//   - blk_bytes=0 without blk_last: err pulse, block dropped.
//   - blk_bytes>16 is treated as 16.
//  Counters: aad_bits and ct_bits are 64-bit; each accepted block adds blk_bytes*8. Counters wrap modulo 2^64 with no flag.
//  start in any state: abort; Y and counters cleared; -> ACCUM. A pending tag is discarded and tag_valid drops next cycle.
//  start has priority over a same-cycle block accept; that block is discarded.
//  h_load accepted only in IDLE or DONE. In other states it is ignored and err pulses.
//   Simultaneous h_load+start in IDLE: both take effect; the new H is used for the first block.
//  rst_n low mid-operation: immediate clear of all state, H included; any tag in flight is lost.
// CONFIGURATION
//  GHASH_AUTOLEN_EN defined: bit counters and the LEN state are present.
//   The controller appends the length block itself and masks partial blocks via blk_bytes.
//  GHASH_AUTOLEN_EN undefined: no counters and no LEN state.
//   blk_bytes is ignored and every block is hashed in full (the blk_bytes=0 and >16 rules above do not apply).
//   Upstream supplies zero-padded blocks and the length block as the final blk_last block.
//   The ordering check stays active; the length block must carry blk_type=1.
// STRUCTURE
//  Package ghash_pkg: FSM state encoding, GHASH_BLK_W=128, GHASH_LEN_W=64, byte-mask function mask_bytes(data, nbytes).
//  Sub-module: gf128_mult (combinational, A=Y^X, B=H), instantiated once, inputs held stable for MULT_CYCLES.
// TESTING
//  1 H=128'h8000..0 (field identity), start, AAD X1=128'h11..11 (16B), CT X2=128'h22..22 (16B,last), autolen
//    -> tag = X1^X2^{64'd128,64'd128}.
//  2 H=0, any three blocks -> tag_out=0. With MULT_CYCLES=3, blk_ready low exactly 2 cycles after each accept.
//  3 Identity H, last CT block blk_bytes=5, data all-ones
//    -> hashed block 128'hFFFFFFFFFF000..0; ct_bits=40 appears in len block.
//  4 CT block then AAD block -> err pulses 1 cycle, AAD block not hashed, final tag equals the run without it.
//  5 start mid-message, then a clean message -> tag equals the clean run alone. h_load during ACCUM -> err, H unchanged.
//  6 tag_ready held low 10 cycles -> tag_valid/tag_out stable, blk_ready=0. Reset asserted in WAIT -> all outputs 0 in that cycle.

Source files
------------

// File: rtl/ghash_pkg.sv
// ghash_pkg: shared widths, FSM encoding, GF(2^128) reduction constant and byte masking for ghash_ctrl.
package ghash_pkg;
  localparam int GHASH_BLK_W = 128;
  localparam int GHASH_LEN_W = 64;
  localparam logic [GHASH_BLK_W-1:0] GF_R = {8'he1, 120'd0};
  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_WAIT, S_LEN, S_DONE} state_t;
  function automatic logic [GHASH_BLK_W-1:0] mask_bytes(input logic [GHASH_BLK_W-1:0] data, input logic [4:0] nbytes);
    logic [GHASH_BLK_W-1:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) m[127-8*i -: 8] = (5'(i) < nbytes) ? 8'hff : 8'h00;
    return data & m;
  endfunction
endpackage

// File: rtl/ghash_ctrl_gf128_mult.sv
// gf128_mult: combinational GF(2^128) multiply in GCM bit order (bit127 = x^0).
module gf128_mult
  import ghash_pkg::*;
(
  input  logic [GHASH_BLK_W-1:0] a,
  input  logic [GHASH_BLK_W-1:0] b,
  output logic [GHASH_BLK_W-1:0] p
);
  logic [GHASH_BLK_W-1:0] v;
  always_comb begin
    p = '0;
    v = b;
    for (int i = 0; i < GHASH_BLK_W; i++) begin
      if (a[GHASH_BLK_W-1-i]) p = p ^ v;
      v = {1'b0, v[GHASH_BLK_W-1:1]} ^ (v[0] ? GF_R : '0);
    end
  end
endmodule

// File: rtl/ghash_ctrl.sv
// ghash_ctrl: sequences one gf128_mult to compute GHASH_H(A,C) and present the tag.
// GHASH_AUTOLEN_EN: when defined, bit counters and the appended length block are built in.
module ghash_ctrl
  import ghash_pkg::*;
#(
  parameter int MULT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   h_load,
  input  logic [GHASH_BLK_W-1:0] h_in,
  input  logic                   start,
  input  logic                   blk_valid,
  output logic                   blk_ready,
  input  logic [GHASH_BLK_W-1:0] blk_data,
  input  logic                   blk_type,
  input  logic                   blk_last,
  input  logic [4:0]             blk_bytes,
  output logic                   busy,
  output logic                   tag_valid,
  input  logic                   tag_ready,
  output logic [GHASH_BLK_W-1:0] tag_out,
  output logic                   err
);
  state_t state_q, state_d, nxt_q, nxt_d, term;
  logic [GHASH_BLK_W-1:0] h_q, h_d, y_q, y_d, a_q, a_d, tag_q, tag_d, blk_x, op, prod;
  logic seen_ct_q, seen_ct_d, rdy_q, rdy_d, busy_q, busy_d, tv_q, tv_d, err_q, err_d;
  logic [1:0] cnt_q, cnt_d;
`ifdef GHASH_AUTOLEN_EN
  logic [GHASH_LEN_W-1:0] aad_q, aad_d, ct_q, ct_d;
  logic [4:0] nb;
  assign nb = (blk_bytes > 5'd16) ? 5'd16 : blk_bytes;
  assign blk_x = mask_bytes(blk_data, nb);
  assign term = blk_last ? S_LEN : S_ACCUM;
  assign op = (state_q == S_WAIT) ? a_q : (state_q == S_LEN) ? y_q ^ {aad_q, ct_q} : y_q ^ blk_x;
`else
  logic unused_bytes;
  assign unused_bytes = ^blk_bytes;
  assign blk_x = blk_data;
  assign term = blk_last ? S_DONE : S_ACCUM;
  assign op = (state_q == S_WAIT) ? a_q : y_q ^ blk_x;
`endif
  gf128_mult u_mult (.a(op), .b(h_q), .p(prod));
  always_comb begin
    state_d = state_q;
    nxt_d = nxt_q;
    h_d = h_q;
    y_d = y_q;
    a_d = a_q;
    seen_ct_d = seen_ct_q;
    cnt_d = cnt_q;
    err_d = 1'b0;
`ifdef GHASH_AUTOLEN_EN
    aad_d = aad_q;
    ct_d = ct_q;
`endif
    if (h_load) begin
      if (state_q == S_IDLE || state_q == S_DONE) h_d = h_in;
      else err_d = 1'b1;
    end
    if (start) begin
      y_d = '0;
      seen_ct_d = 1'b0;
      state_d = S_ACCUM;
`ifdef GHASH_AUTOLEN_EN
      aad_d = '0;
      ct_d = '0;
`endif
    end else begin
      case (state_q)
        S_ACCUM: if (blk_valid && rdy_q) begin
          if (!blk_type && seen_ct_q) err_d = 1'b1;
`ifdef GHASH_AUTOLEN_EN
          else if (nb == 5'd0) begin
            if (blk_last) state_d = S_LEN;
            else err_d = 1'b1;
          end
`endif
          else begin
            seen_ct_d = seen_ct_q | blk_type;
`ifdef GHASH_AUTOLEN_EN
            if (blk_type) ct_d = ct_q + {56'd0, nb, 3'b000};
            else aad_d = aad_q + {56'd0, nb, 3'b000};
`endif
            if (MULT_CYCLES > 1) begin
              a_d = op;
              cnt_d = 2'd1;
              nxt_d = term;
              state_d = S_WAIT;
            end else begin
              y_d = prod;
              state_d = term;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 2'(MULT_CYCLES - 1)) begin
            y_d = prod;
            state_d = nxt_q;
          end else cnt_d = cnt_q + 2'd1;
        end
`ifdef GHASH_AUTOLEN_EN
        S_LEN: begin
          if (MULT_CYCLES > 1) begin
            a_d = op;
            cnt_d = 2'd1;
            nxt_d = S_DONE;
            state_d = S_WAIT;
          end else begin
            y_d = prod;
            state_d = S_DONE;
          end
        end
`endif
        S_DONE: if (tag_ready) state_d = S_IDLE;
        default: ;
      endcase
    end
    rdy_d = state_d == S_ACCUM;
    busy_d = state_d != S_IDLE;
    tv_d = state_d == S_DONE;
    tag_d = tv_d ? y_d : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      nxt_q <= S_IDLE;
      h_q <= '0;
      y_q <= '0;
      a_q <= '0;
      tag_q <= '0;
      seen_ct_q <= 1'b0;
      cnt_q <= '0;
      rdy_q <= 1'b0;
      busy_q <= 1'b0;
      tv_q <= 1'b0;
      err_q <= 1'b0;
`ifdef GHASH_AUTOLEN_EN
      aad_q <= '0;
      ct_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      nxt_q <= nxt_d;
      h_q <= h_d;
      y_q <= y_d;
      a_q <= a_d;
      tag_q <= tag_d;
      seen_ct_q <= seen_ct_d;
      cnt_q <= cnt_d;
      rdy_q <= rdy_d;
      busy_q <= busy_d;
      tv_q <= tv_d;
      err_q <= err_d;
`ifdef GHASH_AUTOLEN_EN
      aad_q <= aad_d;
      ct_q <= ct_d;
`endif
    end
  end
  assign blk_ready = rdy_q;
  assign busy = busy_q;
  assign tag_valid = tv_q;
  assign tag_out = tag_q;
  assign err = err_q;
endmodule
